// File: rtl/approx_err_accum.sv
// approx_err_accum: error statistics of an approximate product stream against its exact reference.
// Define ERR_SIGNED_SUM_EN to add the saturating signed error sum output sum_err.
module approx_err_accum #(
    parameter int PW    = 32,
    parameter int CNT_W = 16,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        n_samples,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PW-1:0]           approx_prod,
    input  logic [PW-1:0]           exact_prod,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        sum_abs_err,
    output logic [PW-1:0]           max_abs_err,
    output logic [CNT_W-1:0]        err_count,
    output logic [CNT_W-1:0]        sample_count
`ifdef ERR_SIGNED_SUM_EN
    ,
    output logic signed [ACC_W-1:0] sum_err
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [PW-1:0] max_q, max_d;
    logic [CNT_W-1:0] err_q, err_d, cnt_q, cnt_d, rem_q, rem_d;
    logic signed [PW:0] diff;
    logic [PW-1:0] abs_diff;
    logic [ACC_W:0] sum_ext;
    logic acc, clr;
    always_comb begin
        clr = state_q == IDLE && start;
        acc = state_q == RUN && in_valid;
        diff = {approx_prod[PW-1], approx_prod} - {exact_prod[PW-1], exact_prod};
        abs_diff = diff[PW] ? PW'(-diff) : diff[PW-1:0];
        sum_ext = {1'b0, sum_q} + {{(ACC_W+1-PW){1'b0}}, abs_diff};
        state_d = state_q == IDLE ? (start ? (n_samples == '0 ? DONE : RUN) : IDLE)
                : state_q == RUN  ? (acc && rem_q == CNT_W'(1) ? DONE : RUN) : IDLE;
        sum_d = clr ? '0 : acc ? (sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0]) : sum_q;
        max_d = clr ? '0 : acc && abs_diff > max_q ? abs_diff : max_q;
        err_d = clr ? '0 : acc && diff != '0 ? err_q + 1'b1 : err_q;
        cnt_d = clr ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
        rem_d = clr ? n_samples : acc ? rem_q - 1'b1 : rem_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            max_q   <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
        end
    end
`ifdef ERR_SIGNED_SUM_EN
    logic signed [ACC_W-1:0] ssum_q, ssum_d;
    logic signed [ACC_W:0] ssum_ext;
    logic ssat;
    always_comb begin
        ssum_ext = {ssum_q[ACC_W-1], ssum_q} + {{(ACC_W-PW){diff[PW]}}, diff};
        ssat = ssum_ext[ACC_W] != ssum_ext[ACC_W-1];
        ssum_d = clr ? '0 : acc ? (ssat ? {ssum_ext[ACC_W], {(ACC_W-1){~ssum_ext[ACC_W]}}}
                                        : ssum_ext[ACC_W-1:0]) : ssum_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) ssum_q <= '0;
        else ssum_q <= ssum_d;
    end
    assign sum_err = ssum_q;
`endif
    assign in_ready     = state_q == RUN;
    assign busy         = state_q == RUN;
    assign done         = state_q == DONE;
    assign sum_abs_err  = sum_q;
    assign max_abs_err  = max_q;
    assign err_count    = err_q;
    assign sample_count = cnt_q;
endmodule
